// File: rtl/nbbpu_mc.sv
// Multi-cycle 16-register load/store core: START/FETCH/EXECUTE/MEM/HALT FSM with registered memory port.
// Optional multiply (opcode D) is enabled by defining NBBPU_MC_MUL_EN; otherwise opcode D is a NOP.
module nbbpu_mc #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic                  halted
);

    typedef enum logic [2:0] {
        S_START,
        S_FETCH,
        S_EXECUTE,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_SHL   = 4'h5;
    localparam logic [3:0] OP_SHR   = 4'h6;
    localparam logic [3:0] OP_LOAD  = 4'h7;
    localparam logic [3:0] OP_STORE = 4'h8;
    localparam logic [3:0] OP_SETL  = 4'h9;
    localparam logic [3:0] OP_BEQ   = 4'hA;
    localparam logic [3:0] OP_JMP   = 4'hB;
    localparam logic [3:0] OP_HALT  = 4'hC;
`ifdef NBBPU_MC_MUL_EN
    localparam logic [3:0] OP_MUL   = 4'hD;
`endif

    localparam logic [6:0] WIDTH_L = 7'(WIDTH);

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   pc_reg;
    logic [15:0]             ir_reg;
    logic [WIDTH-1:0]        rf_reg [16];
    logic                    mem_req_reg;
    logic                    mem_we_reg;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg;
    logic [WIDTH-1:0]        mem_wdata_reg;
    logic                    halted_reg;

    logic [3:0]              op;
    logic [3:0]              fx;
    logic [3:0]              fy;
    logic [3:0]              fz;
    logic [WIDTH-1:0]        rx_val;
    logic [WIDTH-1:0]        ry_val;
    logic [5:0]              shamt;
    logic                    shamt_big;
    logic [WIDTH-1:0]        alu_result;
    logic                    alu_we;
    logic [ADDR_WIDTH-1:0]   pc_inc;
    logic [ADDR_WIDTH-1:0]   pc_branch;
    logic [ADDR_WIDTH-1:0]   pc_next;
    logic                    rf_we;
    logic [WIDTH-1:0]        rf_wdata;
    logic                    xfer_done;

    assign op        = ir_reg[3:0];
    assign fx        = ir_reg[7:4];
    assign fy        = ir_reg[11:8];
    assign fz        = ir_reg[15:12];
    // r0 is never written, so reading it always yields zero.
    assign rx_val    = rf_reg[fx];
    assign ry_val    = rf_reg[fy];
    assign shamt     = ry_val[5:0];
    assign shamt_big = ({1'b0, shamt} >= WIDTH_L);
    assign xfer_done = mem_req_reg && mem_ready;

    assign pc_inc    = pc_reg + ADDR_WIDTH'(1);
    assign pc_branch = pc_inc + {{(ADDR_WIDTH-4){fz[3]}}, fz};

`ifdef NBBPU_MC_MUL_EN
    logic [WIDTH-1:0] mul_result;
    assign mul_result = rx_val * ry_val;
`endif

    always_comb begin
        alu_result = '0;
        alu_we     = 1'b0;
        case (op)
            OP_ADD:  begin alu_result = rx_val + ry_val; alu_we = 1'b1; end
            OP_SUB:  begin alu_result = rx_val - ry_val; alu_we = 1'b1; end
            OP_AND:  begin alu_result = rx_val & ry_val; alu_we = 1'b1; end
            OP_OR:   begin alu_result = rx_val | ry_val; alu_we = 1'b1; end
            OP_XOR:  begin alu_result = rx_val ^ ry_val; alu_we = 1'b1; end
            OP_SHL:  begin alu_result = shamt_big ? '0 : (rx_val << shamt); alu_we = 1'b1; end
            OP_SHR:  begin alu_result = shamt_big ? '0 : (rx_val >> shamt); alu_we = 1'b1; end
            OP_SETL: begin alu_result = {{(WIDTH-8){1'b0}}, fy, fx}; alu_we = 1'b1; end
`ifdef NBBPU_MC_MUL_EN
            OP_MUL:  begin alu_result = mul_result; alu_we = 1'b1; end
`endif
            default: begin alu_result = '0; alu_we = 1'b0; end
        endcase
    end

    always_comb begin
        pc_next = pc_inc;
        case (op)
            OP_BEQ:  pc_next = (rx_val == ry_val) ? pc_branch : pc_inc;
            OP_JMP:  pc_next = rx_val[ADDR_WIDTH-1:0];
            default: pc_next = pc_inc;
        endcase
    end

    // Single register-file write port: ALU results in EXECUTE, load data on MEM completion.
    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = alu_result;
        if (state_reg == S_EXECUTE && alu_we) begin
            rf_we = 1'b1;
        end else if (state_reg == S_MEM && xfer_done && !mem_we_reg) begin
            rf_we    = 1'b1;
            rf_wdata = mem_rdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                rf_reg[i] <= '0;
            end
        end else if (rf_we && fz != 4'd0) begin
            rf_reg[fz] <= rf_wdata;
        end
    end

    // Each memory phase spends one cycle registering the request before it can complete.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_START;
            pc_reg        <= '0;
            ir_reg        <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            halted_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_START: begin
                    mem_req_reg  <= 1'b1;
                    mem_we_reg   <= 1'b0;
                    mem_addr_reg <= pc_reg;
                    state_reg    <= S_FETCH;
                end
                S_FETCH: begin
                    if (!mem_req_reg) begin
                        mem_req_reg  <= 1'b1;
                        mem_we_reg   <= 1'b0;
                        mem_addr_reg <= pc_reg;
                    end else if (mem_ready) begin
                        ir_reg      <= mem_rdata[15:0];
                        mem_req_reg <= 1'b0;
                        state_reg   <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (op == OP_LOAD || op == OP_STORE) begin
                        state_reg <= S_MEM;
                    end else if (op == OP_HALT) begin
                        halted_reg <= 1'b1;
                        state_reg  <= S_HALT;
                    end else begin
                        pc_reg    <= pc_next;
                        state_reg <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (!mem_req_reg) begin
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= (op == OP_STORE);
                        mem_addr_reg  <= rx_val[ADDR_WIDTH-1:0];
                        mem_wdata_reg <= ry_val;
                    end else if (mem_ready) begin
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        pc_reg      <= pc_inc;
                        state_reg   <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state_reg <= S_HALT;
                end
                default: begin
                    state_reg <= S_START;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign PC        = pc_reg;
    assign halted    = halted_reg;

endmodule

// File: tb/tb_nbbpu_mc.sv
// Directed bench for nbbpu_mc: memory model with programmable wait states and a store scoreboard.
module tb_nbbpu_mc;

    localparam int W  = 16;
    localparam int AW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] PC;
    logic          halted;

    nbbpu_mc #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .PC        (PC),
        .halted    (halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } st_t;

    logic [15:0] mem [0:65535];
    st_t         sb [$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          fetch_done [0:63];
    int          wcnt = 0;
    int          need;
    bit          slow_data = 0;
    bit          hold_ready = 0;
    bit          saw_ffff = 0;
    logic [15:0] cap_addr;
    logic        cap_we;
    logic [15:0] cap_wdata;

    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Memory model: evaluated mid-cycle so the DUT's registered request is stable.
    always @(negedge clock) begin
        if (mem_req) begin
            if (wcnt == 0) begin
                cap_addr  = mem_addr;
                cap_we    = mem_we;
                cap_wdata = mem_wdata;
            end else begin
                chk("hold_addr", 32'(mem_addr), 32'(cap_addr));
                chk("hold_we", 32'(mem_we), 32'(cap_we));
                chk("hold_wdata", 32'(mem_wdata), 32'(cap_wdata));
            end
            if (hold_ready && mem_addr == 16'h0050)
                need = 1000000;
            else if (slow_data && mem_addr >= 16'h0040 && mem_addr < 16'h0050)
                need = 3;
            else
                need = 0;
            if (wcnt >= need) begin
                mem_ready = 1'b1;
                wcnt = 0;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    tests++;
                    assert (sb.size() != 0) else begin
                        fails++;
                        $error("FAIL sb_unexpected_store: observed addr %h data %h expected none", mem_addr, mem_wdata);
                    end
                    if (sb.size() != 0) begin
                        st_t e;
                        e = sb.pop_front();
                        chk("sb_store_addr", 32'(mem_addr), 32'(e.addr));
                        chk("sb_store_data", 32'(mem_wdata), 32'(e.data));
                    end
                end else if (mem_addr < 16'h0040) begin
                    fetch_done[mem_addr[5:0]] = cyc;
                end else if (mem_addr == 16'hFFFF) begin
                    saw_ffff = 1;
                end
            end else begin
                mem_ready = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
        end
    end

    task automatic clear_all();
        for (int i = 0; i < 65536; i++) mem[i] = 16'h000C;
        for (int i = 0; i < 64; i++) fetch_done[i] = 0;
        sb.delete();
        saw_ffff = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_pc", 32'(PC), 32'h0);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_halt(output int n, input int max_cyc);
        n = 0;
        while (!halted && n < max_cyc) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("halt_reached", 32'(halted), 32'h1);
    endtask

    initial begin
        int  n;
        int  rst_cyc;
        bit  found;
        logic [15:0] mul_exp;

        // Basic program, exact halt cycle
        clear_all();
        mem[0] = 16'h1059; mem[1] = 16'h2039; mem[2] = 16'h3210; mem[3] = 16'h000C;
        do_reset();
        wait_halt(n, 200);
        $display("[TB] basic: halted after %0d cycles PC=%h r3=%h", n, PC, dut.rf_reg[3]);
        chk("basic_cycles", 32'(n), 32'd12);
        chk("basic_pc", 32'(PC), 32'h3);
        chk("basic_r3", 32'(dut.rf_reg[3]), 32'h8);
        chk("basic_r1", 32'(dut.rf_reg[1]), 32'h5);

        // Store/load with 3 wait cycles on data transfers
        clear_all();
        mem[0] = 16'h1409; mem[1] = 16'h2039; mem[2] = 16'h0218; mem[3] = 16'h4017;
        mem[4] = 16'h5419; mem[5] = 16'h0458; mem[6] = 16'h000C;
        mem[16'h40] = 16'h1234;
        sb.push_back('{16'h0040, 16'h0003});
        sb.push_back('{16'h0041, 16'h0003});
        slow_data = 1;
        do_reset();
        wait_halt(n, 300);
        slow_data = 0;
        $display("[TB] ldst: PC=%h r4=%h store_lat=%0d load_lat=%0d", PC, dut.rf_reg[4],
                 fetch_done[3] - fetch_done[2], fetch_done[4] - fetch_done[3]);
        chk("ldst_r4", 32'(dut.rf_reg[4]), 32'h3);
        chk("ldst_pc", 32'(PC), 32'h6);
        chk("lat_alu", 32'(fetch_done[2] - fetch_done[1]), 32'd3);
        chk("lat_store", 32'(fetch_done[3] - fetch_done[2]), 32'd8);
        chk("lat_load", 32'(fetch_done[4] - fetch_done[3]), 32'd8);
        chk("ldst_sb_empty", 32'(sb.size()), 32'd0);

        // BEQ taken backwards from PC=10
        clear_all();
        mem[0] = 16'h1079; mem[1] = 16'h2079; mem[2] = 16'h30A9; mem[3] = 16'h003B;
        mem[10] = 16'hE21A;
        do_reset();
        wait_halt(n, 200);
        $display("[TB] beq_taken: PC=%h", PC);
        chk("beq_taken_pc", 32'(PC), 32'h9);

        // BEQ not taken
        mem[1] = 16'h2089;
        do_reset();
        wait_halt(n, 200);
        $display("[TB] beq_not_taken: PC=%h", PC);
        chk("beq_fall_pc", 32'(PC), 32'hB);

        // SUB 0-1 wrap and PC wrap from 0xFFFF
        clear_all();
        mem[0] = 16'h107A; mem[2] = 16'h7019; mem[3] = 16'h2019; mem[4] = 16'h1201;
        mem[5] = 16'h5429; mem[6] = 16'h0158; mem[7] = 16'h001B;
        mem[16'hFFFF] = 16'h3210;
        sb.push_back('{16'h0042, 16'hFFFF});
        do_reset();
        wait_halt(n, 300);
        $display("[TB] wrap: PC=%h r1=%h r3=%h saw_ffff=%0d", PC, dut.rf_reg[1], dut.rf_reg[3], saw_ffff);
        chk("wrap_pc", 32'(PC), 32'h1);
        chk("wrap_r1", 32'(dut.rf_reg[1]), 32'hFFFF);
        chk("wrap_r3", 32'(dut.rf_reg[3]), 32'h0);
        chk("wrap_fetch_ffff", 32'(saw_ffff), 32'h1);
        chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

        // Opcode D
`ifdef NBBPU_MC_MUL_EN
        mul_exp = 16'h0100;
`else
        mul_exp = 16'h0077;
`endif
        clear_all();
        mem[0] = 16'h1809; mem[1] = 16'h1110; mem[2] = 16'h2019; mem[3] = 16'h2210;
        mem[4] = 16'h3779; mem[5] = 16'h321D; mem[6] = 16'h5439; mem[7] = 16'h0358;
        mem[8] = 16'h000C;
        sb.push_back('{16'h0043, mul_exp});
        do_reset();
        wait_halt(n, 300);
        $display("[TB] opd: PC=%h r1=%h r2=%h r3=%h", PC, dut.rf_reg[1], dut.rf_reg[2], dut.rf_reg[3]);
        chk("opd_r1", 32'(dut.rf_reg[1]), 32'h0100);
        chk("opd_r2", 32'(dut.rf_reg[2]), 32'h0101);
        chk("opd_r3", 32'(dut.rf_reg[3]), 32'(mul_exp));
        chk("opd_pc", 32'(PC), 32'h8);
        chk("opd_sb_empty", 32'(sb.size()), 32'd0);

        // Logic, shifts (including amount >= WIDTH), r0 write discard, SUB wrap
        clear_all();
        mem[0]  = 16'h1A59; mem[1]  = 16'h23C9; mem[2]  = 16'h9049; mem[3]  = 16'hB109;
        mem[4]  = 16'h3212; mem[5]  = 16'h4213; mem[6]  = 16'h5214; mem[7]  = 16'h6915;
        mem[8]  = 16'h7916; mem[9]  = 16'h8B15; mem[10] = 16'h0FF9; mem[11] = 16'hA121;
        mem[12] = 16'h000E; mem[13] = 16'hCB16; mem[14] = 16'h000C;
        mem[16'h2C] = 16'h0000;
        do_reset();
        wait_halt(n, 300);
        $display("[TB] alu: PC=%h and=%h or=%h xor=%h shl=%h shr=%h", PC, dut.rf_reg[3],
                 dut.rf_reg[4], dut.rf_reg[5], dut.rf_reg[6], dut.rf_reg[7]);
        chk("alu_and", 32'(dut.rf_reg[3]), 32'h0024);
        chk("alu_or", 32'(dut.rf_reg[4]), 32'h00BD);
        chk("alu_xor", 32'(dut.rf_reg[5]), 32'h0099);
        chk("alu_shl", 32'(dut.rf_reg[6]), 32'h0A50);
        chk("alu_shr", 32'(dut.rf_reg[7]), 32'h000A);
        chk("alu_shl_big", 32'(dut.rf_reg[8]), 32'h0000);
        chk("alu_r0", 32'(dut.rf_reg[0]), 32'h0000);
        chk("alu_sub", 32'(dut.rf_reg[10]), 32'hFF97);
        chk("alu_shr_big", 32'(dut.rf_reg[12]), 32'h0000);
        chk("alu_pc", 32'(PC), 32'hE);

        // Reset during a stalled LOAD
        clear_all();
        mem[0] = 16'h1509; mem[1] = 16'h4669; mem[2] = 16'h4017; mem[3] = 16'h000C;
        mem[16'h50] = 16'hBEEF;
        hold_ready = 1;
        do_reset();
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clock);
            if (mem_req && mem_addr == 16'h0050) found = 1;
        end
        chk("abort_load_seen", 32'(found), 32'h1);
        chk("abort_r4_before", 32'(dut.rf_reg[4]), 32'h0066);
        repeat (2) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        $display("[TB] abort: mem_req=%0d PC=%h r4=%h", mem_req, PC, dut.rf_reg[4]);
        chk("abort_req_drop", 32'(mem_req), 32'h0);
        chk("abort_pc", 32'(PC), 32'h0);
        chk("abort_r4", 32'(dut.rf_reg[4]), 32'h0000);
        rst_cyc = cyc;
        hold_ready = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        wait_halt(n, 200);
        $display("[TB] restart: PC=%h r4=%h", PC, dut.rf_reg[4]);
        chk("restart_r4", 32'(dut.rf_reg[4]), 32'hBEEF);
        chk("restart_pc", 32'(PC), 32'h3);
        chk("restart_fetch0", 32'(fetch_done[0] > rst_cyc), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nbbpu_mc.md
NBBPU_MC -- requirements
Module: nbbpu_mc

Interface
REQ-001 Parameter WIDTH, default 16, register/ALU/data-bus width in bits; legal values 16..64.
REQ-002 Parameter ADDR_WIDTH, default 16, word-address width of mem_addr and PC; legal values 8..WIDTH.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mem_req  output  1  memory transfer request.
REQ-006 mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-007 mem_addr  output  ADDR_WIDTH  word address.
REQ-008 mem_wdata  output  WIDTH  store data.
REQ-009 mem_rdata  input  WIDTH  read data; instruction fetches use bits [15:0].
REQ-010 mem_ready  input  1  transfer completes on a rising edge where mem_req=1 and mem_ready=1.
REQ-011 PC  output  ADDR_WIDTH  current program counter.
REQ-012 halted  output  1  core is stopped in HALT.

Function
REQ-013 Instruction fields: opcode=[3:0], x=[7:4], y=[11:8], z=[15:12]; 16 registers r0..r15, each WIDTH bits; r0 reads 0 and writes are discarded.
REQ-014 Opcodes: 0 ADD rz=rx+ry; 1 SUB rz=rx-ry; 2 AND; 3 OR; 4 XOR; 5 SHL rz=rx<<ry[5:0]; 6 SHR (logical) rz=rx>>ry[5:0]; 7 LOAD rz=mem[rx]; 8 STORE mem[rx]=ry; 9 SETL rz=zero-extended {y,x}; A BEQ; B JMP PC=rx[ADDR_WIDTH-1:0]; C HALT; D MUL (see Configuration); E,F NOP.
REQ-015 Arithmetic is modulo 2^WIDTH, with no flags kept; shift amounts >= WIDTH yield 0.
REQ-016 BEQ: if rx==ry, PC=PC+1+sign-extended z; otherwise PC=PC+1; PC arithmetic is modulo 2^ADDR_WIDTH.
REQ-017 Memory addresses are rx[ADDR_WIDTH-1:0].
REQ-018 FSM states: START, FETCH, EXECUTE, MEM, HALT.
REQ-019 START -> FETCH on the first rising edge after reset deasserts.
REQ-020 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on completion, latch mem_rdata[15:0] into IR and go to EXECUTE.
REQ-021 EXECUTE (one cycle, mem_req=0): LOAD/STORE -> MEM; HALT -> HALT with PC unchanged; all others write back rz (if applicable), update PC, and return to FETCH.
REQ-022 MEM: mem_req=1; mem_we=1 for STORE, 0 for LOAD; LOAD writes rz with mem_rdata on completion; then PC=PC+1 and return to FETCH.
REQ-023 mem_req, mem_we, mem_addr and mem_wdata are driven from registered state and held stable until completion; mem_ready is ignored while mem_req=0.
REQ-024 Minimum latency: 3 cycles for ALU/branch instructions and 5 cycles for LOAD/STORE when mem_ready is constantly 1; each wait cycle adds one cycle.
REQ-025 HALT: mem_req=0 and halted=1; the core leaves HALT only via reset.
REQ-026 A write to rz where z=x or z=y uses the old operand values.

Reset
REQ-027 While reset=0: state=START, PC=0, IR=0, all registers 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0.
REQ-028 Reset asserted mid-transfer aborts the transfer immediately; no register or PC update occurs from the aborted instruction.

Configuration
REQ-029 Macro NBBPU_MC_MUL_EN defined: opcode D performs rz=(rx*ry) mod 2^WIDTH in EXECUTE with the same latency as ADD.
REQ-030 NBBPU_MC_MUL_EN undefined: opcode D is a NOP (PC=PC+1), and no multiplier is synthesised.

Verification
REQ-031 Reset, then mem_ready=1 with program {SETL r1,0x05; SETL r2,0x03; ADD r3,r1,r2; HALT} -> r3=8, halted=1 at cycle 12, PC=3.
REQ-032 STORE r2 to mem[r1=0x40], then LOAD r4 from mem[0x40], with mem_ready held low 3 cycles per transfer -> address/data/we stable throughout the wait, r4=3, and each instruction takes 3 extra cycles.
REQ-033 BEQ with r1==r2 and z=0xE at PC=10 -> next fetch at address 9; with r1!=r2 -> next fetch at address 11.
REQ-034 PC=0xFFFF executing ADD (ADDR_WIDTH=16) -> next fetch at address 0x0000; SUB 0-1 -> 0xFFFF at WIDTH=16.
REQ-035 Opcode D with rx=0x0100, ry=0x0101 -> rz=0x0100 with NBBPU_MC_MUL_EN defined; rz unchanged and PC+1 without it.
REQ-036 reset pulled low during a LOAD with mem_ready=0 -> mem_req drops immediately, rz unchanged, and execution restarts from PC=0.
